// File: rtl/pattern_detector_param_if.sv
// Bus bundle for pattern_detector_param: sample strobe, serial data and count clear in,
// match indication, saturating count and history view out.
interface pattern_detector_param_if #(
    parameter int unsigned PATTERN_WIDTH = 2,
    parameter int unsigned COUNT_WIDTH   = 8
) ();
    logic                     enable;
    logic                     a;
    logic                     clear_count;
    logic                     match;
    logic [COUNT_WIDTH-1:0]   match_count;
    logic                     count_overflow;
    logic [PATTERN_WIDTH-1:0] history;

    modport master (
        output enable, a, clear_count,
        input  match, match_count, count_overflow, history
    );

    modport slave (
        input  enable, a, clear_count,
        output match, match_count, count_overflow, history
    );
endinterface

// File: rtl/pattern_detector_param.sv
// Parametrised serial pattern detector with Moore/Mealy output, overlap control and a
// saturating match counter with sticky overflow.
module pattern_detector_param #(
    parameter int unsigned              PATTERN_WIDTH = 2,
    parameter logic [PATTERN_WIDTH-1:0] PATTERN       = 2'b01,
    parameter bit                       MOORE         = 1'b1,
    parameter bit                       OVERLAP       = 1'b1,
    parameter int unsigned              COUNT_WIDTH   = 8
) (
    input logic                   clock,
    input logic                   reset,
    pattern_detector_param_if.slave bus
);

    localparam int unsigned FW = (PATTERN_WIDTH < 2) ? 1 : $clog2(PATTERN_WIDTH);
    localparam logic [FW-1:0]          FILL_MAX  = FW'(PATTERN_WIDTH - 1);
    localparam logic [FW-1:0]          FILL_ONE  = FW'(1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = COUNT_WIDTH'(1);

    if (PATTERN_WIDTH < 2 || PATTERN_WIDTH > 32) begin : g_bad_width
        $error("pattern_detector_param: PATTERN_WIDTH must be in 2..32");
    end

    logic [PATTERN_WIDTH-1:0] history_q;
    logic [PATTERN_WIDTH-1:0] shifted;
    logic [FW-1:0]            fill_q;
    logic                     moore_q;
    logic [COUNT_WIDTH-1:0]   count_q;
    logic                     overflow_q;
    logic                     hit;

    // fill gates the compare so no match can form from bits left over before reset/restart
    always_comb begin
        shifted = {history_q[PATTERN_WIDTH-2:0], bus.a};
        hit     = bus.enable && (fill_q == FILL_MAX) && (shifted == PATTERN);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            history_q  <= '0;
            fill_q     <= '0;
            moore_q    <= 1'b0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (bus.enable) begin
                history_q <= shifted;
                moore_q   <= hit;
                if (hit && (OVERLAP == 1'b0)) begin
                    fill_q <= '0;
                end else if (fill_q != FILL_MAX) begin
                    fill_q <= fill_q + FILL_ONE;
                end
            end
            // clear wins over a coincident event, which is then dropped
            if (bus.clear_count) begin
                count_q    <= '0;
                overflow_q <= 1'b0;
            end else if (hit) begin
                if (&count_q) begin
                    overflow_q <= 1'b1;
                end else begin
                    count_q <= count_q + COUNT_ONE;
                end
            end
        end
    end

    assign bus.match          = reset ? 1'b0 : (MOORE ? moore_q : hit);
    assign bus.match_count    = count_q;
    assign bus.count_overflow = overflow_q;
    assign bus.history        = history_q;

endmodule
